cfs_sc_fifo: RTL and testbench
==============================

Name: cfs_sc_fifo

Overview:
Single-clock, parametrised FIFO with valid/ready handshake on both sides. It supports any depth (including non-power-of-2), a selectable output mode (fall-through or registered), runtime almost-full/almost-empty thresholds, synchronous flush and a peak-level watermark. It buffers traffic between two blocks in the same clock domain, where no clock-domain crossing is required.

Parameters:
DATA_WIDTH, 32, data word width; legal >= 1 (elaboration-time assertion).
FIFO_DEPTH, 8, total capacity in words; legal >= 2; non-power-of-2 allowed.
OUTPUT_REG, 0, 0 = fall-through (pop_data combinational from storage); 1 = pop_data/pop_valid driven directly from flops.
CNT_WIDTH (localparam), $clog2(FIFO_DEPTH), pointer width; level/threshold width is CNT_WIDTH+1.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear; has priority over push and pop.
push_valid  in  1  write request.
push_data  in  DATA_WIDTH  write data.
push_ready  out  1  = !reset & !flush & (level < FIFO_DEPTH); independent of push_valid.
pop_valid  out  1  head word available.
pop_data  out  DATA_WIDTH  head word; don't-care when pop_valid=0.
pop_ready  in  1  read acknowledge.
af_lvl  in  CNT_WIDTH+1  almost-full threshold.
ae_lvl  in  CNT_WIDTH+1  almost-empty threshold.
fifo_lvl  out  CNT_WIDTH+1  words accepted and not yet popped, registered.
full  out  1  fifo_lvl == FIFO_DEPTH.
empty  out  1  fifo_lvl == 0.
almost_full  out  1  fifo_lvl >= af_lvl, combinational from fifo_lvl.
almost_empty  out  1  fifo_lvl <= ae_lvl, combinational from fifo_lvl.
max_lvl  out  CNT_WIDTH+1  peak fifo_lvl since the last reset or flush.

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, fifo_lvl, max_lvl = 0; pop_valid = 0; push_ready = 0 while reset is high; pop_data flop (OUTPUT_REG=1) = 0. The memory array is not reset.
- Handshakes:
  - push_hs = push_valid & push_ready.
  - pop_hs = pop_valid & pop_ready.
  - push_ready never depends on pop_ready: no push into a full FIFO even when a pop happens in the same cycle.
  - Producer may hold push_valid while push_ready = 0 (backpressure); this is legal, not an error.
- Level update: fifo_lvl_next = fifo_lvl + push_hs - pop_hs. It never exceeds FIFO_DEPTH and never underflows.
- Watermark: max_lvl_next = max(max_lvl, fifo_lvl_next).
- Pointers: advance on each handshake; value FIFO_DEPTH-1 wraps to 0.
- OUTPUT_REG=0:
  - pop_valid = (fifo_lvl != 0) & !flush; pop_data = mem[rd_ptr].
  - Latency: word pushed at edge k is poppable after edge k.
  - Push+pop on empty in one cycle: only the push occurs.
- OUTPUT_REG=1:
  - Output flop holds the head word; fifo_lvl counts memory words plus the output flop.
  - Output flop loads from memory when it is empty or popped and a memory word is present.
  - First-word latency: push at edge k gives pop_valid=1 after edge k+1.
  - Back-to-back pops sustain 1 word/cycle once primed.
  - Capacity stays exactly FIFO_DEPTH.
- Simultaneous push+pop with 0 < fifo_lvl < FIFO_DEPTH: fifo_lvl unchanged; ordering is preserved.
- Flush:
  - At an edge with flush=1: pointers, fifo_lvl, max_lvl and output-flop valid clear to 0.
  - push_ready and pop_valid are forced 0 combinationally, so no handshake counts in that cycle.
  - Normal operation resumes the next cycle.
- Thresholds: af_lvl/ae_lvl may change any cycle and take effect combinationally. af_lvl=0 gives almost_full=1 always; ae_lvl >= FIFO_DEPTH gives almost_empty=1 always.
- Reset mid-operation: all state is lost immediately; no partial word is delivered after release.

Decomposition:
- Package cfs_sc_fifo_pkg: no typedefs. It holds the function next_ptr(ptr, depth) (wrap-around increment) and the OUTPUT_REG mode constants (CFS_FIFO_FWFT = 0, CFS_FIFO_REGOUT = 1).
- One sub-module, cfs_sc_fifo_ptr: a parametrised wrapping pointer register with async reset, sync clear and increment enable. It is instantiated once for wr_ptr and once for rd_ptr.
- Storage stays inline in cfs_sc_fifo.

Test Plan:
1. DEPTH=5, OUTPUT_REG=0, pop_ready=0: push 0x11..0x15 -> push_ready=0 after 5th push; full=1; fifo_lvl=5, max_lvl=5; a 6th push_valid is held off, not accepted.
2. From full, pop_ready=1 for 7 cycles -> pops 0x11..0x15 in order; pop_valid=0 after 5th pop; empty=1; max_lvl stays 5.
3. DEPTH=5, OUTPUT_REG=1: single push 0xA5 at edge k -> pop_valid=1 after edge k+1 with pop_data=0xA5; fifo_lvl=1 from edge k.
4. Continuous push+pop at fifo_lvl=3 for 12 cycles, crossing pointer wrap at 4->0 -> fifo_lvl stays 3; output sequence equals input sequence; no gaps.
5. af_lvl=4, ae_lvl=1: fill 0->5 -> almost_empty=1 at levels 0-1, almost_full=1 at levels 4-5; change af_lvl to 2 at level 3 -> almost_full=1 the same cycle.
6. At level 3, assert flush with push_valid=pop_ready=1 -> no handshake; next cycle fifo_lvl=0, max_lvl=0, pop_valid=0, push_ready=1. Repeat with reset mid-stream -> same state; push_ready=0 while reset is high.

Source files
------------

// File: rtl/cfs_sc_fifo_pkg.sv
// Shared definitions for the cfs_sc_fifo block.
//   CFS_FIFO_FWFT / CFS_FIFO_REGOUT : values for the OUTPUT_REG parameter.
//   next_ptr(ptr, depth)            : wrap-around pointer increment.
//                                     depth-1 (or above) goes to 0.
package cfs_sc_fifo_pkg;

  localparam int CFS_FIFO_FWFT   = 0;
  localparam int CFS_FIFO_REGOUT = 1;

  // The depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr,
                                           input logic [31:0] depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/cfs_sc_fifo_ptr.sv
// Wrapping pointer register for cfs_sc_fifo.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, pointer -> 0
//   clr_i  : synchronous clear, has priority over inc_i
//   inc_i  : advance the pointer by one, wrapping at DEPTH-1
//   ptr_o  : current pointer value
module cfs_sc_fifo_ptr
  import cfs_sc_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = PTR_W'(next_ptr(32'(ptr_q), 32'(DEPTH)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/cfs_sc_fifo.sv
// Single-clock FIFO with valid/ready handshakes on both sides, any depth >= 2,
// fall-through or registered output, runtime almost-full/almost-empty
// thresholds, synchronous flush and a peak-level watermark.
// Ports:
//   clk, reset           : clock and asynchronous active-high reset
//   flush                : synchronous clear, beats push and pop
//   push_valid/ready/data: write side handshake
//   pop_valid/ready/data : read side handshake
//   af_lvl, ae_lvl       : almost-full / almost-empty thresholds
//   fifo_lvl             : words held (memory plus output flop)
//   full, empty          : level == depth / level == 0
//   almost_full/empty    : level >= af_lvl / level <= ae_lvl
//   max_lvl              : peak level since the last reset or flush
module cfs_sc_fifo
  import cfs_sc_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  FIFO_DEPTH = 8,
  parameter int  OUTPUT_REG = 0,
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_ready,
  input  logic [CNT_WIDTH:0]    af_lvl,
  input  logic [CNT_WIDTH:0]    ae_lvl,
  output logic [CNT_WIDTH:0]    fifo_lvl,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH:0]    max_lvl
);

  localparam int                LVL_W     = CNT_WIDTH + 1;
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("cfs_sc_fifo: DATA_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("cfs_sc_fifo: FIFO_DEPTH must be >= 2");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  rd_ptr;
  logic [LVL_W-1:0]      lvl_q, lvl_d;
  logic [LVL_W-1:0]      max_q, max_d;
  logic                  push_hs;
  logic                  pop_hs;
  logic                  rd_adv;

  // push_ready deliberately ignores pop_ready: a full FIFO never accepts a
  // word even if the head leaves in the same cycle.
  assign push_ready = !reset && !flush && (lvl_q < DEPTH_LVL);
  assign push_hs    = push_valid && push_ready;
  assign pop_hs     = pop_valid && pop_ready;

  cfs_sc_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PTR_W(CNT_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .inc_i (push_hs),
    .ptr_o (wr_ptr)
  );

  cfs_sc_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PTR_W(CNT_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .inc_i (rd_adv),
    .ptr_o (rd_ptr)
  );

  // Storage is not reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push_hs) begin
      mem[wr_ptr] <= push_data;
    end
  end

  if (OUTPUT_REG == CFS_FIFO_REGOUT) begin : g_regout
    logic                  ovld_q, ovld_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic [LVL_W-1:0]      mem_cnt;
    logic                  load;

    // The level includes the output flop, so memory occupancy is level minus
    // the flop's valid bit. A word written this edge is not yet readable, which
    // gives the extra cycle of first-word latency.
    assign mem_cnt = lvl_q - LVL_W'(ovld_q);
    assign load    = (mem_cnt != '0) && (!ovld_q || pop_hs);

    always_comb begin
      ovld_d  = ovld_q;
      odata_d = odata_q;
      if (flush) begin
        ovld_d = 1'b0;
      end else if (load) begin
        ovld_d  = 1'b1;
        odata_d = mem[rd_ptr];
      end else if (pop_hs) begin
        ovld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ovld_q  <= 1'b0;
        odata_q <= '0;
      end else begin
        ovld_q  <= ovld_d;
        odata_q <= odata_d;
      end
    end

    assign pop_valid = ovld_q && !flush;
    assign pop_data  = odata_q;
    assign rd_adv    = load && !flush;
  end else begin : g_fwft
    assign pop_valid = (lvl_q != '0) && !flush;
    assign pop_data  = mem[rd_ptr];
    assign rd_adv    = pop_hs;
  end

  always_comb begin
    lvl_d = lvl_q + LVL_W'(push_hs) - LVL_W'(pop_hs);
    max_d = (lvl_d > max_q) ? lvl_d : max_q;
    if (flush) begin
      lvl_d = '0;
      max_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= '0;
      max_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      max_q <= max_d;
    end
  end

  assign fifo_lvl     = lvl_q;
  assign max_lvl      = max_q;
  assign full         = (lvl_q == DEPTH_LVL);
  assign empty        = (lvl_q == '0);
  assign almost_full  = (lvl_q >= af_lvl);
  assign almost_empty = (lvl_q <= ae_lvl);

endmodule

// File: tb/tb_cfs_sc_fifo.sv
module tb_cfs_sc_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_ready = 1'b0;
  logic [3:0]    af_lvl = 4'd4;
  logic [3:0]    ae_lvl = 4'd1;

  logic          pr0, pv0, fu0, em0, afo0, aeo0;
  logic [DW-1:0] pd0;
  logic [3:0]    lv0, mx0;
  logic          pr1, pv1, fu1, em1, afo1, aeo1;
  logic [DW-1:0] pd1;
  logic [3:0]    lv1, mx1;

  always #5 clk = ~clk;

  cfs_sc_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .OUTPUT_REG(0)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(pr0),
    .pop_valid(pv0), .pop_data(pd0), .pop_ready(pop_ready),
    .af_lvl(af_lvl), .ae_lvl(ae_lvl), .fifo_lvl(lv0),
    .full(fu0), .empty(em0), .almost_full(afo0), .almost_empty(aeo0),
    .max_lvl(mx0)
  );

  cfs_sc_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .OUTPUT_REG(1)) u_reg (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(pr1),
    .pop_valid(pv1), .pop_data(pd1), .pop_ready(pop_ready),
    .af_lvl(af_lvl), .ae_lvl(ae_lvl), .fifo_lvl(lv1),
    .full(fu1), .empty(em1), .almost_full(afo1), .almost_empty(aeo1),
    .max_lvl(mx1)
  );

  // Reference model: a queue of words per DUT, each tagged with the edge
  // number at which it was accepted. In registered mode the head becomes
  // visible only from the edge after it was accepted.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [31:0]   e;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  int          mx_m[2];
  bit          phs[2];
  bit          xhs[2];
  logic [31:0] edge_n = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic eval_mode(input int m);
    ent_t          q[$];
    logic          pr, pv, fu, em, afo, aeo;
    logic [DW-1:0] pd;
    logic [3:0]    lv, mx;
    bit            e_pr, e_pv;
    int            sz;
    string         s;
    if (m == 0) begin
      q = q0; pr = pr0; pv = pv0; pd = pd0; lv = lv0; mx = mx0;
      fu = fu0; em = em0; afo = afo0; aeo = aeo0; s = "fwft";
    end else begin
      q = q1; pr = pr1; pv = pv1; pd = pd1; lv = lv1; mx = mx1;
      fu = fu1; em = em1; afo = afo1; aeo = aeo1; s = "regout";
    end
    sz   = q.size();
    e_pr = !reset && !flush && (sz < DEPTH);
    e_pv = 1'b0;
    if (!reset && !flush && sz > 0) begin
      e_pv = (m == 0) || (q[0].e < edge_n);
    end
    check_val({s, " push_ready"}, pr, e_pr);
    check_val({s, " pop_valid"}, pv, e_pv);
    check_val({s, " fifo_lvl"}, lv, sz);
    check_val({s, " max_lvl"}, mx, mx_m[m]);
    check_val({s, " full"}, fu, sz == DEPTH);
    check_val({s, " empty"}, em, sz == 0);
    check_val({s, " almost_full"}, afo, sz >= int'(af_lvl));
    check_val({s, " almost_empty"}, aeo, sz <= int'(ae_lvl));
    if (e_pv) begin
      check_val({s, " pop_data"}, pd, q[0].d);
    end
    phs[m] = push_valid && e_pr;
    xhs[m] = pop_ready && e_pv;
  endtask

  task automatic update_mode(input int m);
    ent_t q[$];
    if (m == 0) q = q0; else q = q1;
    if (reset || flush) begin
      q.delete();
      mx_m[m] = 0;
    end else begin
      if (xhs[m]) void'(q.pop_front());
      if (phs[m]) q.push_back(ent_t'{push_data, edge_n});
      if (q.size() > mx_m[m]) mx_m[m] = q.size();
    end
    if (m == 0) q0 = q; else q1 = q;
  endtask

  // Called at edge+1 with inputs already driven; checks mid-cycle, then
  // advances the model across the next rising edge.
  task automatic cycle();
    #4;
    eval_mode(0);
    eval_mode(1);
    @(posedge clk);
    edge_n++;
    update_mode(0);
    update_mode(1);
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    mx_m[0] = 0;
    mx_m[1] = 0;
  endtask

  initial begin
    mx_m[0] = 0;
    mx_m[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();                      // still in reset: push_ready low, level 0
    reset = 1'b0;
    cycle();

    // Fill to full, sixth push held off by backpressure.
    pop_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_valid = 1'b1;
      push_data  = DW'(8'h11 + i);
      cycle();
    end
    push_valid = 1'b0;
    cycle();

    // Drain with pop_ready high for 7 cycles.
    pop_ready = 1'b1;
    repeat (7) cycle();

    // Single word latency.
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'hA5;
    cycle();
    push_valid = 1'b0;
    repeat (2) cycle();
    pop_ready = 1'b1;
    cycle();

    // Prime to level 3 then stream through pointer wrap.
    pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_data  = DW'(8'h30 + i);
      cycle();
    end
    pop_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_data = DW'(8'h40 + i);
      cycle();
    end

    // Drain, then threshold sweep 0..5 with af changed at level 3.
    push_valid = 1'b0;
    repeat (6) cycle();
    pop_ready = 1'b0;
    af_lvl    = 4'd4;
    ae_lvl    = 4'd1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) af_lvl = 4'd2;
      push_valid = (i < 5);
      push_data  = DW'(8'h50 + i);
      cycle();
    end

    // Down to level 3, then flush while both sides request.
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    repeat (2) cycle();
    flush      = 1'b1;
    push_valid = 1'b1;
    cycle();
    flush      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    cycle();

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_data  = DW'(8'h60 + i);
      cycle();
    end
    pop_ready = 1'b1;
    assert_reset();
    repeat (2) cycle();
    reset = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    cycle();

    // Randomized traffic with varying bias, thresholds, flushes and resets.
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias       = (i / 100) % 4;
      push_valid = ($urandom_range(0, 3) < bias + 1);
      pop_ready  = ($urandom_range(0, 3) >= bias);
      push_data  = DW'($urandom);
      flush      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) af_lvl = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ae_lvl = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) begin
        assert_reset();
        cycle();
        reset = 1'b0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
